// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks a one-hot column drive, samples rows once per column dwell,
// debounces whole-frame results and reports single-key press/release events or multi-key state.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    localparam int CODE_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   r,
    output logic [COLS-1:0]   c,
    output logic [CODE_W-1:0] key_code,
    output logic              key_down,
    output logic              key_press,
    output logic              key_release,
    output logic              multi
);

    localparam int COL_W = $clog2(COLS);
    localparam int DW_W  = $clog2(SCAN_DIV);
    localparam int SC_W  = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } result_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_MULTI
    } state_e;

    logic [DW_W-1:0]   dwellCnt;
    logic [COL_W-1:0]  colIdx;
    logic              sampleNow;
    logic              frameEnd;

    logic [1:0]        colHits;
    logic [CODE_W-1:0] colCode;
    logic [1:0]        accHits;
    logic [CODE_W-1:0] accCode;
    logic [2:0]        rawSum;
    logic [1:0]        sumHits;
    logic [CODE_W-1:0] sumCode;

    result_e           frameRes;
    result_e           prevRes;
    logic [CODE_W-1:0] prevCode;
    logic [SC_W-1:0]   stableCnt;
    logic [SC_W-1:0]   nextStable;
    logic              sameAsPrev;
    logic              differs;
    logic              accept;

    state_e            state;
    state_e            stateNext;
    logic [CODE_W-1:0] codeNext;
    logic              pressNext;
    logic              releaseNext;

    assign sampleNow = (dwellCnt == DW_W'(SCAN_DIV - 1));
    assign frameEnd  = sampleNow && (colIdx == COL_W'(COLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            dwellCnt <= '0;
            colIdx   <= '0;
        end else if (sampleNow) begin
            dwellCnt <= '0;
            colIdx   <= frameEnd ? '0 : colIdx + 1'b1;
        end else begin
            dwellCnt <= dwellCnt + 1'b1;
        end
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < COLS; k++) begin
            c[COLS-1-k] = (colIdx == COL_W'(k));
        end
    end

    // Rows of the current column: saturated hit count and code of the lowest-index row.
    always_comb begin
        colHits = 2'd0;
        colCode = '0;
        for (int j = 0; j < ROWS; j++) begin
            if (r[j] && colHits != 2'd2) begin
                colHits = colHits + 2'd1;
            end
        end
        for (int j = ROWS - 1; j >= 0; j--) begin
            if (r[ROWS-1-j]) begin
                colCode = CODE_W'(j * COLS) + CODE_W'(colIdx);
            end
        end
    end

    always_comb begin
        rawSum  = {1'b0, accHits} + {1'b0, colHits};
        sumHits = (rawSum >= 3'd2) ? 2'd2 : rawSum[1:0];
        sumCode = (accHits == 2'd0) ? colCode : accCode;
        if (sumHits == 2'd0) begin
            frameRes = RES_NONE;
        end else if (sumHits == 2'd1) begin
            frameRes = RES_SINGLE;
        end else begin
            frameRes = RES_MULTI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || frameEnd) begin
            accHits <= 2'd0;
            accCode <= '0;
        end else if (sampleNow) begin
            accHits <= sumHits;
            accCode <= sumCode;
        end
    end

    // Two single-key frames only match when they name the same key.
    always_comb begin
        sameAsPrev = (frameRes == prevRes) &&
                     ((frameRes != RES_SINGLE) || (sumCode == prevCode));
        if (!sameAsPrev) begin
            nextStable = SC_W'(1);
        end else if (stableCnt == SC_W'(DEBOUNCE)) begin
            nextStable = stableCnt;
        end else begin
            nextStable = stableCnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prevRes   <= RES_NONE;
            prevCode  <= '0;
            stableCnt <= '0;
        end else if (frameEnd) begin
            prevRes   <= frameRes;
            prevCode  <= sumCode;
            stableCnt <= nextStable;
        end
    end

    always_comb begin
        case (state)
            ST_IDLE:  differs = (frameRes != RES_NONE);
            ST_HELD:  differs = !((frameRes == RES_SINGLE) && (sumCode == key_code));
            ST_MULTI: differs = (frameRes != RES_MULTI);
            default:  differs = 1'b1;
        endcase
        accept = frameEnd && (nextStable == SC_W'(DEBOUNCE)) && differs;
    end

    always_comb begin
        stateNext   = state;
        codeNext    = key_code;
        pressNext   = 1'b0;
        releaseNext = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && frameRes == RES_SINGLE) begin
                    stateNext = ST_HELD;
                    codeNext  = sumCode;
                    pressNext = 1'b1;
                end else if (accept && frameRes == RES_MULTI) begin
                    stateNext = ST_MULTI;
                end
            end
            ST_HELD: begin
                if (accept) begin
                    releaseNext = 1'b1;
                    if (frameRes == RES_SINGLE) begin
                        codeNext  = sumCode;
                        pressNext = 1'b1;
                    end else if (frameRes == RES_MULTI) begin
                        stateNext = ST_MULTI;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end
            end
            ST_MULTI: begin
                if (accept && frameRes == RES_SINGLE) begin
                    stateNext = ST_HELD;
                    codeNext  = sumCode;
                    pressNext = 1'b1;
                end else if (accept && frameRes == RES_NONE) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            key_code    <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= stateNext;
            key_code    <= codeNext;
            key_press   <= pressNext;
            key_release <= releaseNext;
        end
    end

    assign key_down = (state == ST_HELD);
    assign multi    = (state == ST_MULTI);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 instance driven by a key-matrix model with a frame-level
// debounce reference, plus a 3x5 instance exercising non-default geometry.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int NK       = ROWS * COLS;
    localparam int FRAME    = COLS * SCAN_DIV;
    localparam int CW       = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ROWS-1:0] r = '0;
    logic [COLS-1:0] c;
    logic [CW-1:0]   key_code;
    logic            key_down, key_press, key_release, multi;

    logic            rst2 = 1'b1;
    logic [2:0]      r2 = '0;
    logic [4:0]      c2;
    logic [3:0]      key_code2;
    logic            key_down2, key_press2, key_release2, multi2;

    keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .rst(rst), .r(r), .c(c), .key_code(key_code), .key_down(key_down),
        .key_press(key_press), .key_release(key_release), .multi(multi)
    );

    keypad_scanner #(.ROWS(3), .COLS(5), .SCAN_DIV(2), .DEBOUNCE(1)) dut2 (
        .clk(clk), .rst(rst2), .r(r2), .c(c2), .key_code(key_code2), .key_down(key_down2),
        .key_press(key_press2), .key_release(key_release2), .multi(multi2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NK-1:0] keys;
        int            frames;
    } seg_t;

    int            assertCount = 0;
    int            failCount   = 0;
    int            t = 0;
    bit            modelValid = 1'b0;
    int            hist[$];
    int            accepted = -1;
    logic [CW-1:0] expCode = '0;
    bit            expDown, expMulti, expPress, expRelease;
    logic [NK-1:0] curKeys = '0;
    int            framesLeft = 0;
    seg_t          segs[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, t, observed, expected);
        end
    endtask

    function automatic logic [NK-1:0] keyMask(input int code);
        logic [NK-1:0] m;
        m = '0;
        m[code] = 1'b1;
        return m;
    endfunction

    // Result of one frame: -1 no key, -2 two or more keys, else code of first key by column then row.
    function automatic int frameResult(input logic [NK-1:0] keys);
        int n, first;
        n = 0;
        first = -1;
        for (int k = 0; k < COLS; k++) begin
            for (int j = 0; j < ROWS; j++) begin
                if (keys[j*COLS+k]) begin
                    n++;
                    if (first < 0) first = j * COLS + k;
                end
            end
        end
        if (n == 0) return -1;
        if (n >= 2) return -2;
        return first;
    endfunction

    function automatic seg_t randomSeg();
        seg_t s;
        int kind;
        kind = $urandom_range(0, 9);
        s.keys = '0;
        if (kind >= 3 && kind < 7) begin
            s.keys[$urandom_range(0, NK-1)] = 1'b1;
        end else if (kind >= 7) begin
            repeat ($urandom_range(2, 3)) s.keys[$urandom_range(0, NK-1)] = 1'b1;
        end
        s.frames = $urandom_range(1, 5);
        return s;
    endfunction

    task automatic modelReset();
        t = 0;
        hist.delete();
        accepted   = -1;
        expCode    = '0;
        expDown    = 1'b0;
        expMulti   = 1'b0;
        expPress   = 1'b0;
        expRelease = 1'b0;
    endtask

    // A new state is accepted once the last DEBOUNCE frames since reset agree and differ from it.
    task automatic frameDone(input int res);
        bit steady;
        hist.push_back(res);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        if (hist.size() == DEBOUNCE) begin
            steady = 1'b1;
            foreach (hist[i]) if (hist[i] != res) steady = 1'b0;
            if (steady && res != accepted) begin
                expPress   = (res >= 0);
                expRelease = (accepted >= 0);
                if (res >= 0) expCode = CW'(res);
                expDown    = (res >= 0);
                expMulti   = (res == -2);
                accepted   = res;
            end
        end
    endtask

    task automatic applyStimulus();
        int k, dwell;
        seg_t s;
        dwell = t % SCAN_DIV;
        k     = (t / SCAN_DIV) % COLS;
        if (t % FRAME == 0) begin
            if (framesLeft == 0) begin
                if (segs.size() > 0) s = segs.pop_front();
                else s = randomSeg();
                curKeys    = s.keys;
                framesLeft = s.frames;
            end
            framesLeft--;
        end
        expPress   = 1'b0;
        expRelease = 1'b0;
        if (dwell == SCAN_DIV - 1) begin
            for (int j = 0; j < ROWS; j++) r[ROWS-1-j] = curKeys[j*COLS+k];
            if (k == COLS - 1) frameDone(frameResult(curKeys));
        end else begin
            r = ROWS'($urandom);
        end
    endtask

    task automatic checkAll();
        logic [COLS-1:0] ec;
        ec = '0;
        ec[COLS-1-((t / SCAN_DIV) % COLS)] = 1'b1;
        checkOutput("c", 32'(c), 32'(ec));
        checkOutput("key_code", 32'(key_code), 32'(expCode));
        checkOutput("key_down", 32'(key_down), 32'(expDown));
        checkOutput("multi", 32'(multi), 32'(expMulti));
        checkOutput("key_press", 32'(key_press), 32'(expPress));
        checkOutput("key_release", 32'(key_release), 32'(expRelease));
    endtask

    task automatic stepCycle(input bit doReset);
        if (modelValid) checkAll();
        if (doReset) begin
            rst = 1'b1;
            r   = ROWS'($urandom);
            modelReset();
            modelValid = 1'b1;
        end else begin
            rst = 1'b0;
            applyStimulus();
            t++;
        end
        @(negedge clk);
    endtask

    task automatic pushSeg(input logic [NK-1:0] keys, input int frames);
        seg_t s;
        s.keys   = keys;
        s.frames = frames;
        segs.push_back(s);
    endtask

    initial begin
        logic [4:0] ec2;
        pushSeg('0, 1);
        pushSeg(keyMask(6), 5);
        pushSeg('0, 4);
        pushSeg(keyMask(6), 1);
        pushSeg('0, 1);
        pushSeg(keyMask(6), 1);
        pushSeg('0, 2);
        pushSeg(keyMask(6), 4);
        pushSeg('0, 4);
        pushSeg(keyMask(0), 4);
        pushSeg(keyMask(6) | keyMask(9), 4);
        pushSeg(keyMask(6), 4);
        pushSeg('0, 4);

        @(negedge clk);
        @(negedge clk);
        stepCycle(1'b1);
        repeat (6) stepCycle(1'b0);
        stepCycle(1'b1);
        repeat (750) stepCycle(1'b0);
        for (int n = 0; n < 4000; n++) stepCycle($urandom_range(0, 599) == 0);

        for (int t2 = 0; t2 < 25; t2++) begin
            t = t2;
            if (t2 == 0) rst2 = 1'b0;
            ec2 = 5'b10000 >> ((t2 / 2) % 5);
            checkOutput("c2", 32'(c2), 32'(ec2));
            checkOutput("key_press2", 32'(key_press2), 32'(t2 == 10));
            checkOutput("key_down2", 32'(key_down2), 32'(t2 >= 10));
            if (t2 >= 10) checkOutput("key_code2", 32'(key_code2), 32'd14);
            checkOutput("multi2", 32'(multi2), 32'd0);
            checkOutput("key_release2", 32'(key_release2), 32'd0);
            if (t2 % 10 == 9) r2 = 3'b001;
            else if (t2 % 2 == 0) r2 = 3'b111;
            else r2 = 3'b000;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
